// File: rtl/cpu_controller.sv
// Instruction-sequencing FSM for the 16-bit CPU datapath: fetch, PC update,
// decode, execute, write-back, load/store and halt control, one state per cycle.
module cpu_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        halted
);

  localparam logic [4:0] S_RST       = 5'd0;
  localparam logic [4:0] S_IF1       = 5'd1;
  localparam logic [4:0] S_IF2       = 5'd2;
  localparam logic [4:0] S_UPDATE_PC = 5'd3;
  localparam logic [4:0] S_DECODE    = 5'd4;
  localparam logic [4:0] S_WRITE_IMM = 5'd5;
  localparam logic [4:0] S_GET_A     = 5'd6;
  localparam logic [4:0] S_GET_B     = 5'd7;
  localparam logic [4:0] S_EXEC      = 5'd8;
  localparam logic [4:0] S_WRITE_REG = 5'd9;
  localparam logic [4:0] S_ADDR      = 5'd10;
  localparam logic [4:0] S_LOAD_ADDR = 5'd11;
  localparam logic [4:0] S_MEM_RD1   = 5'd12;
  localparam logic [4:0] S_MEM_RD2   = 5'd13;
  localparam logic [4:0] S_STR_GET_B = 5'd14;
  localparam logic [4:0] S_STR_EXEC  = 5'd15;
  localparam logic [4:0] S_STR_WRITE = 5'd16;
  localparam logic [4:0] S_HALT      = 5'd17;

  logic [4:0] state, next_state;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = instr[15:13];
  assign op     = instr[12:11];
  assign rn     = instr[10:8];
  assign rd     = instr[7:5];
  assign sh     = instr[4:3];
  assign rm     = instr[2:0];

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_ldr, is_str, is_halt;
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_ldr     = (opcode == 3'b011) && (op == 2'b00);
  assign is_str     = (opcode == 3'b100) && (op == 2'b00);
  assign is_halt    = (opcode == 3'b111);

  assign sximm8 = {{8{instr[7]}}, instr[7:0]};
  assign sximm5 = {{11{instr[4]}}, instr[4:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_RST;
    else          state <= next_state;
  end

  always_comb begin
    next_state = S_RST;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    addr_sel   = 1'b0;
    load_addr  = 1'b0;
    mem_cmd    = 2'b00;
    write      = 1'b0;
    vsel       = 2'b00;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    shift      = 2'b00;
    ALUop      = 2'b00;
    halted     = 1'b0;
    case (state)
      S_RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        next_state = S_IF1;
      end
      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = 2'b01;
        next_state = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = 2'b01;
        load_ir    = 1'b1;
        next_state = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                     next_state = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)      next_state = S_GET_B;
        else if (is_alu || is_ldr || is_str) next_state = S_GET_A;
        else if (is_halt)                   next_state = S_HALT;
        else                                next_state = S_IF1;
      end
      S_WRITE_IMM: begin
        writenum   = rn;
        vsel       = 2'b01;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = (is_ldr || is_str) ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        // MOV passes B through A=0 (asel), MVN inverts B; others use the opcode's op field
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else if (is_mvn) begin
          asel  = 1'b1;
          ALUop = 2'b11;
        end else begin
          ALUop = op;
        end
        if (is_cmp) begin
          loads      = 1'b1;
          next_state = S_IF1;
        end else begin
          loadc      = 1'b1;
          next_state = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum   = rd;
        vsel       = 2'b11;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_ADDR: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        next_state = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        load_addr  = 1'b1;
        next_state = is_ldr ? S_MEM_RD1 : S_STR_GET_B;
      end
      S_MEM_RD1: begin
        mem_cmd    = 2'b01;
        next_state = S_MEM_RD2;
      end
      S_MEM_RD2: begin
        mem_cmd    = 2'b01;
        writenum   = rd;
        vsel       = 2'b00;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_STR_GET_B: begin
        readnum    = rd;
        loadb      = 1'b1;
        next_state = S_STR_EXEC;
      end
      S_STR_EXEC: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        next_state = S_STR_WRITE;
      end
      S_STR_WRITE: begin
        mem_cmd    = 2'b10;
        next_state = S_IF1;
      end
      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed per-cycle checks of every control output for each instruction class,
// plus immediate extension, halt hold and reset from halt / mid-instruction.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        load_ir, load_pc, reset_pc, addr_sel, load_addr, write;
  logic        loada, loadb, asel, bsel, loadc, loads, halted;
  logic [1:0]  mem_cmd, vsel, shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8, sximm5;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .instr(instr),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .readnum(readnum), .writenum(writenum), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .halted(halted)
  );

  typedef struct packed {
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       write;
    logic [1:0] vsel;
    logic       loada, loadb, asel, bsel, loadc, loads;
    logic [2:0] readnum, writenum;
    logic [1:0] shift, alu_op;
    logic       halted;
  } ctl_t;

  ctl_t ctl;
  assign ctl = {load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, write, vsel,
                loada, loadb, asel, bsel, loadc, loads, readnum, writenum, shift, ALUop, halted};

  // Bench-side state labels; EXEC is split by instruction flavour
  localparam int T_RST = 0, T_IF1 = 1, T_IF2 = 2, T_UPD = 3, T_DEC = 4, T_WIMM = 5;
  localparam int T_GETA = 6, T_GETB = 7, T_EXA = 8, T_EXC = 9, T_EXM = 10, T_EXN = 11;
  localparam int T_WREG = 12, T_ADDR = 13, T_LADDR = 14, T_RD1 = 15, T_RD2 = 16;
  localparam int T_SGETB = 17, T_SEXEC = 18, T_SWR = 19, T_HALT = 20;

  function automatic ctl_t exp_ctl(int st, logic [15:0] ins);
    ctl_t e;
    e = '0;
    case (st)
      T_RST:   begin e.reset_pc = 1'b1; e.load_pc = 1'b1; end
      T_IF1:   begin e.addr_sel = 1'b1; e.mem_cmd = 2'b01; end
      T_IF2:   begin e.addr_sel = 1'b1; e.mem_cmd = 2'b01; e.load_ir = 1'b1; end
      T_UPD:   e.load_pc = 1'b1;
      T_WIMM:  begin e.writenum = ins[10:8]; e.vsel = 2'b01; e.write = 1'b1; end
      T_GETA:  begin e.readnum = ins[10:8]; e.loada = 1'b1; end
      T_GETB:  begin e.readnum = ins[2:0]; e.loadb = 1'b1; end
      T_EXA:   begin e.shift = ins[4:3]; e.alu_op = ins[12:11]; e.loadc = 1'b1; end
      T_EXC:   begin e.shift = ins[4:3]; e.alu_op = 2'b01; e.loads = 1'b1; end
      T_EXM:   begin e.shift = ins[4:3]; e.asel = 1'b1; e.loadc = 1'b1; end
      T_EXN:   begin e.shift = ins[4:3]; e.asel = 1'b1; e.alu_op = 2'b11; e.loadc = 1'b1; end
      T_WREG:  begin e.writenum = ins[7:5]; e.vsel = 2'b11; e.write = 1'b1; end
      T_ADDR:  begin e.bsel = 1'b1; e.loadc = 1'b1; end
      T_LADDR: e.load_addr = 1'b1;
      T_RD1:   e.mem_cmd = 2'b01;
      T_RD2:   begin e.mem_cmd = 2'b01; e.writenum = ins[7:5]; e.write = 1'b1; end
      T_SGETB: begin e.readnum = ins[7:5]; e.loadb = 1'b1; end
      T_SEXEC: begin e.asel = 1'b1; e.loadc = 1'b1; end
      T_SWR:   e.mem_cmd = 2'b10;
      T_HALT:  e.halted = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    ctl_t e;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    e = exp_ctl(T_RST, 16'h0000);
    nvec++;
    if (ctl !== e) begin nerr++; $display("FAIL reset_held got %h want %h", ctl, e); end
    reset_n = 1'b1;
    nvec++;
    if (ctl !== e) begin nerr++; $display("FAIL reset_rst got %h want %h", ctl, e); end
    @(negedge clk);
    e = exp_ctl(T_IF1, 16'h0000);
    nvec++;
    if (ctl !== e) begin nerr++; $display("FAIL reset_if1 got %h want %h", ctl, e); end
  endtask

  task automatic test_mov_imm();
    logic [15:0] ins [2];
    logic [15:0] want8 [2];
    int seq [6];
    ctl_t e;
    ins   = '{16'hD105, 16'hD1FB};
    want8 = '{16'h0005, 16'hFFFB};
    seq   = '{T_IF1, T_IF2, T_UPD, T_DEC, T_WIMM, T_IF1};
    for (int k = 0; k < 2; k++) begin
      instr = ins[k];
      for (int i = 0; i < 6; i++) begin
        if (i > 0) @(negedge clk);
        e = exp_ctl(seq[i], ins[k]);
        nvec++;
        if (ctl !== e) begin nerr++; $display("FAIL mov_imm %h cyc%0d got %h want %h", ins[k], i + 1, ctl, e); end
        if (i == 4) begin
          nvec++;
          if (sximm8 !== want8[k]) begin nerr++; $display("FAIL sximm8 %h got %h want %h", ins[k], sximm8, want8[k]); end
        end
      end
    end
  endtask

  task automatic test_alu();
    logic [15:0] ins [5];
    int len [5];
    int tail [5][5];
    int st;
    ctl_t e;
    ins  = '{16'hA2A9, 16'hB1DF, 16'hAA01, 16'hC074, 16'hB8A1};
    len  = '{9, 9, 8, 8, 8};
    tail = '{'{T_GETA, T_GETB, T_EXA, T_WREG, T_IF1},
             '{T_GETA, T_GETB, T_EXA, T_WREG, T_IF1},
             '{T_GETA, T_GETB, T_EXC, T_IF1,  T_IF1},
             '{T_GETB, T_EXM,  T_WREG, T_IF1, T_IF1},
             '{T_GETB, T_EXN,  T_WREG, T_IF1, T_IF1}};
    for (int k = 0; k < 5; k++) begin
      instr = ins[k];
      for (int i = 0; i < len[k]; i++) begin
        if (i > 0) @(negedge clk);
        if (i < 4) st = T_IF1 + i;
        else       st = tail[k][i-4];
        e = exp_ctl(st, ins[k]);
        nvec++;
        if (ctl !== e) begin nerr++; $display("FAIL alu %h cyc%0d got %h want %h", ins[k], i + 1, ctl, e); end
      end
    end
  endtask

  task automatic test_ldr_str();
    int sl [10];
    int ss [11];
    ctl_t e;
    sl = '{T_IF1, T_IF2, T_UPD, T_DEC, T_GETA, T_ADDR, T_LADDR, T_RD1, T_RD2, T_IF1};
    ss = '{T_IF1, T_IF2, T_UPD, T_DEC, T_GETA, T_ADDR, T_LADDR, T_SGETB, T_SEXEC, T_SWR, T_IF1};
    instr = 16'h6243;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_ctl(sl[i], 16'h6243);
      nvec++;
      if (ctl !== e) begin nerr++; $display("FAIL ldr cyc%0d got %h want %h", i + 1, ctl, e); end
      if (i == 5) begin
        nvec++;
        if (sximm5 !== 16'h0003) begin nerr++; $display("FAIL ldr_sximm5 got %h want 0003", sximm5); end
      end
    end
    instr = 16'h8263;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_ctl(ss[i], 16'h8263);
      nvec++;
      if (ctl !== e) begin nerr++; $display("FAIL str cyc%0d got %h want %h", i + 1, ctl, e); end
    end
  endtask

  task automatic test_undefined();
    logic [15:0] ins [3];
    ctl_t e;
    ins = '{16'h001F, 16'hC800, 16'h6800};
    for (int k = 0; k < 3; k++) begin
      instr = ins[k];
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        e = exp_ctl((i < 4) ? T_IF1 + i : T_IF1, ins[k]);
        nvec++;
        if (ctl !== e) begin nerr++; $display("FAIL undef %h cyc%0d got %h want %h", ins[k], i + 1, ctl, e); end
      end
      if (k == 0) begin
        nvec++;
        if (sximm5 !== 16'hFFFF || sximm8 !== 16'h001F) begin
          nerr++; $display("FAIL sximm_neg got %h/%h want FFFF/001F", sximm5, sximm8);
        end
      end
    end
  endtask

  task automatic test_halt();
    ctl_t e;
    instr = 16'hE000;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_ctl((i < 4) ? T_IF1 + i : T_HALT, 16'hE000);
      nvec++;
      if (ctl !== e) begin nerr++; $display("FAIL halt cyc%0d got %h want %h", i + 1, ctl, e); end
    end
    reset_n = 1'b0;
    @(negedge clk);
    e = exp_ctl(T_RST, 16'hE000);
    nvec++;
    if (ctl !== e) begin nerr++; $display("FAIL halt_reset got %h want %h", ctl, e); end
    reset_n = 1'b1;
    @(negedge clk);
    e = exp_ctl(T_IF1, 16'hE000);
    nvec++;
    if (ctl !== e) begin nerr++; $display("FAIL halt_reset_if1 got %h want %h", ctl, e); end
  endtask

  task automatic test_reset_mid_exec();
    int seq [7];
    ctl_t e;
    seq = '{T_IF1, T_IF2, T_UPD, T_DEC, T_GETA, T_GETB, T_EXA};
    instr = 16'hA2A9;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_ctl(seq[i], 16'hA2A9);
      nvec++;
      if (ctl !== e) begin nerr++; $display("FAIL midrst cyc%0d got %h want %h", i + 1, ctl, e); end
    end
    reset_n = 1'b0;
    @(negedge clk);
    e = exp_ctl(T_RST, 16'hA2A9);
    nvec++;
    if (ctl !== e || write !== 1'b0) begin nerr++; $display("FAIL midrst_rst got %h want %h", ctl, e); end
    reset_n = 1'b1;
    @(negedge clk);
    e = exp_ctl(T_IF1, 16'hA2A9);
    nvec++;
    if (ctl !== e) begin nerr++; $display("FAIL midrst_if1 got %h want %h", ctl, e); end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu();
    test_ldr_str();
    test_undefined();
    test_halt();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
